// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: field layout, opcodes and FSM states.
package alu_sequencer_pkg;

    localparam int unsigned DataW    = 8;
    localparam int unsigned AddrW    = 8;
    localparam int unsigned InstrW   = 16;
    localparam int unsigned NumRegs  = 4;
    localparam int unsigned RegAddrW = 2;
    localparam int unsigned AluSW    = 2;

    // IR field positions: op[15:12], rd[11:10], rs[9:8], imm[7:0]
    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 12;
    localparam int unsigned RdMsb  = 11;
    localparam int unsigned RdLsb  = 10;
    localparam int unsigned RsMsb  = 9;
    localparam int unsigned RsLsb  = 8;
    localparam int unsigned ImmMsb = 7;
    localparam int unsigned ImmLsb = 0;

    localparam logic [3:0] OpNop  = 4'd0;
    localparam logic [3:0] OpAlu  = 4'd1;
    localparam logic [3:0] OpLdi  = 4'd2;
    localparam logic [3:0] OpJmp  = 4'd3;
    localparam logic [3:0] OpJz   = 4'd4;
    localparam logic [3:0] OpJnz  = 4'd5;
    localparam logic [3:0] OpIn   = 4'd6;
    localparam logic [3:0] OpOut  = 4'd7;
    localparam logic [3:0] OpHalt = 4'd8;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StExec,
        StWaitIn,
        StWaitOut,
        StHalt
    } state_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of program-memory, ALU, byte-stream and status signals around the sequencer.
interface alu_sequencer_if;
    import alu_sequencer_pkg::*;

    logic                start;
    logic [AddrW-1:0]    imem_addr;
    logic [InstrW-1:0]   imem_data;
    logic [DataW-1:0]    alu_a;
    logic [DataW-1:0]    alu_b;
    logic [AluSW-1:0]    alu_s;
    logic [DataW-1:0]    alu_c;
    logic                alu_z;
    logic [DataW-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DataW-1:0]    out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;
    logic                halted;
    logic                zflag;

    // Sequencer side
    modport master (
        input  start, imem_data, alu_c, alu_z, in_data, in_valid, out_ready,
        output imem_addr, alu_a, alu_b, alu_s, in_ready, out_data, out_valid,
        output busy, halted, zflag
    );

    // Environment side: program ROM, ALU, byte source/sink
    modport slave (
        output start, imem_data, alu_c, alu_z, in_data, in_valid, out_ready,
        input  imem_addr, alu_a, alu_b, alu_s, in_ready, out_data, out_valid,
        input  busy, halted, zflag
    );

endinterface

// File: rtl/seq_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port.
module seq_regfile
    import alu_sequencer_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [RegAddrW-1:0] raddr_a_i,
    output logic [DataW-1:0]    rdata_a_o,
    input  logic [RegAddrW-1:0] raddr_b_i,
    output logic [DataW-1:0]    rdata_b_o,
    input  logic                we_i,
    input  logic [RegAddrW-1:0] waddr_i,
    input  logic [DataW-1:0]    wdata_i
);

    logic [NumRegs-1:0][DataW-1:0] regs_q, regs_d;

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

    // Next register contents: single write port
    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Storage with synchronous clear that overrides any pending write
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer: fetches 16-bit instructions, drives an external ALU and moves bytes
// between an inbound and an outbound valid/ready stream.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu_sequencer_if.master bus
);

    state_e              state_q, state_d;
    logic [AddrW-1:0]    pc_q, pc_d;
    logic [InstrW-1:0]   ir_q, ir_d;
    logic                zflag_q, zflag_d;
    logic [DataW-1:0]    out_data_q, out_data_d;

    logic [3:0]          op;
    logic [RegAddrW-1:0] rd, rs;
    logic [DataW-1:0]    imm;
    logic                rf_we;
    logic [DataW-1:0]    rf_wdata;
    logic [DataW-1:0]    rdata_a, rdata_b;

    assign op  = ir_q[OpMsb:OpLsb];
    assign rd  = ir_q[RdMsb:RdLsb];
    assign rs  = ir_q[RsMsb:RsLsb];
    assign imm = ir_q[ImmMsb:ImmLsb];

    seq_regfile u_regfile (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .raddr_a_i (rs),
        .rdata_a_o (rdata_a),
        .raddr_b_i (rd),
        .rdata_b_o (rdata_b),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata)
    );

    assign bus.imem_addr = pc_q;
    assign bus.alu_a     = rdata_a;
    assign bus.alu_b     = rdata_b;
    assign bus.alu_s     = ir_q[AluSW-1:0];
    assign bus.in_ready  = (state_q == StWaitIn);
    assign bus.out_valid = (state_q == StWaitOut);
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (state_q != StIdle) && (state_q != StHalt);
    assign bus.halted    = (state_q == StHalt);
    assign bus.zflag     = zflag_q;

    // Next-state, PC, IR, flag and register-write decode
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        zflag_d    = zflag_q;
        out_data_d = out_data_q;
        rf_we      = 1'b0;
        rf_wdata   = imm;

        unique case (state_q)
            StIdle, StHalt: begin
                if (bus.start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: state_d = StLoad;
            StLoad: begin
                ir_d    = bus.imem_data;
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                pc_d    = pc_q + 8'd1;  // wraps 255 -> 0
                case (op)
                    OpAlu: begin
                        rf_we    = 1'b1;
                        rf_wdata = bus.alu_c;
                        zflag_d  = bus.alu_z;
                    end
                    OpLdi: rf_we = 1'b1;
                    OpJmp: pc_d = imm;
                    OpJz:  if (zflag_q) pc_d = imm;
                    OpJnz: if (!zflag_q) pc_d = imm;
                    OpIn:  state_d = StWaitIn;
                    OpOut: begin
                        out_data_d = rdata_a;
                        state_d    = StWaitOut;
                    end
                    OpHalt: state_d = StHalt;
                    default: ;  // NOP and unused opcodes
                endcase
            end
            StWaitIn: begin
                if (bus.in_valid) begin
                    rf_we    = 1'b1;
                    rf_wdata = bus.in_data;
                    state_d  = StFetch;
                end
            end
            StWaitOut: begin
                if (bus.out_ready) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            ir_q       <= '0;
            zflag_q    <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            zflag_q    <= zflag_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: an instruction-level model predicts PC steps and output bytes,
// monitors compare what the sequencer actually does.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    logic clk;
    logic rst_n;

    alu_sequencer_if bus ();

    alu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] rom [256];
    logic [7:0]  pc_exp[$];
    logic [7:0]  out_exp[$];
    logic [7:0]  in_model[$];
    logic [7:0]  in_feed[$];

    logic [7:0]  m_regs [4];
    logic        m_z;
    logic [7:0]  m_pc;

    bit          mon_en = 1'b0;
    logic [7:0]  last_addr;
    bit          out_hold;
    logic [7:0]  held;
    int          in_cfg  = -1;
    int          out_cfg = -1;

    // Environment ALU: returns {z, c}
    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] s);
        logic [7:0] c;
        logic       z;
        case (s)
            2'd0:    begin c = a + b; z = (a > b); end
            2'd1:    begin c = b - a; z = (a < b); end
            2'd2:    begin c = a & b; z = (c == 8'd0); end
            default: begin c = a ^ b; z = (c == 8'd0); end
        endcase
        return {z, c};
    endfunction

    logic [8:0] alu_r;
    assign alu_r     = alu_f(bus.alu_a, bus.alu_b, bus.alu_s);
    assign bus.alu_c = alu_r[7:0];
    assign bus.alu_z = alu_r[8];

    // Synchronous program ROM
    always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

    function automatic logic [15:0] ins(input logic [3:0] op, input int rd, input int rs,
                                        input int imm);
        return {op, 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inbound byte source: waits in_cfg cycles (random if negative) after in_ready
    initial begin
        int d;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (bus.in_ready) begin
                d = (in_cfg < 0) ? int'($urandom_range(0, 4)) : in_cfg;
                repeat (d) begin @(posedge clk); #1; end
                if (in_feed.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL in_feed: no inbound byte left to supply");
                    bus.in_data = 8'h00;
                end else begin
                    bus.in_data = in_feed.pop_front();
                end
                bus.in_valid = 1'b1;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
            end
        end
    end

    // Outbound sink: holds out_ready low for out_cfg cycles after out_valid
    initial begin
        int cnt = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                if (cnt == 0) bus.out_ready = 1'b1;
                else cnt--;
            end else begin
                bus.out_ready = 1'b0;
                cnt = (out_cfg < 0) ? int'($urandom_range(0, 3)) : out_cfg;
            end
        end
    end

    // Monitor: every PC change and every output transfer is checked against the queues
    always @(negedge clk) begin
        if (!mon_en) begin
            last_addr = 8'h00;
            out_hold  = 1'b0;
        end else if (rst_n) begin
            if (bus.imem_addr !== last_addr) begin
                if (pc_exp.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL pc_step: imem_addr moved to %0h, expected no change",
                             bus.imem_addr);
                end else begin
                    chk("pc_step", bus.imem_addr, pc_exp.pop_front());
                end
                last_addr = bus.imem_addr;
            end
            if (bus.out_valid) begin
                if (out_hold) chk("out_stable", bus.out_data, held);
                else begin
                    out_hold = 1'b1;
                    held     = bus.out_data;
                end
                if (bus.out_ready) begin
                    if (out_exp.size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL out_data: got %0h, expected no transfer", bus.out_data);
                    end else begin
                        chk("out_data", bus.out_data, out_exp.pop_front());
                    end
                    out_hold = 1'b0;
                end
            end else begin
                out_hold = 1'b0;
            end
        end
    end

    // Instruction-level model: runs the program in rom from address 0 until HALT
    task automatic model_run();
        logic [15:0] w;
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [7:0]  imm, npc;
        logic [8:0]  r;
        bit          done = 1'b0;
        int          steps = 0;
        if (m_pc != 8'd0) pc_exp.push_back(8'd0);
        m_pc = 8'd0;
        while (!done && steps < 1000) begin
            w = rom[m_pc];
            op = w[15:12]; rd = w[11:10]; rs = w[9:8]; imm = w[7:0];
            npc = m_pc + 8'd1;
            case (op)
                OpAlu: begin
                    r = alu_f(m_regs[rs], m_regs[rd], imm[1:0]);
                    m_regs[rd] = r[7:0];
                    m_z = r[8];
                end
                OpLdi: m_regs[rd] = imm;
                OpJmp: npc = imm;
                OpJz:  if (m_z) npc = imm;
                OpJnz: if (!m_z) npc = imm;
                OpIn: begin
                    if (in_model.size() > 0) m_regs[rd] = in_model.pop_front();
                    else m_regs[rd] = 8'h00;
                end
                OpOut:  out_exp.push_back(m_regs[rs]);
                OpHalt: done = 1'b1;
                default: ;
            endcase
            if (npc != m_pc) pc_exp.push_back(npc);
            m_pc = npc;
            steps++;
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL model_run: program did not reach HALT");
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic set_inputs(input int n);
        logic [7:0] b;
        in_model.delete();
        in_feed.delete();
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            in_model.push_back(b);
            in_feed.push_back(b);
        end
    endtask

    // Forward-only jumps guarantee termination; ends by dumping R0..R3 and halting
    task automatic gen_random(input int n);
        int sel, rd, rs, imm, tgt;
        clear_rom();
        for (int k = 0; k < n; k++) begin
            sel = $urandom_range(0, 11);
            rd  = $urandom_range(0, 3);
            rs  = $urandom_range(0, 3);
            imm = $urandom_range(0, 255);
            tgt = $urandom_range(k + 1, n);
            case (sel)
                0:       rom[k] = ins(OpNop, rd, rs, imm);
                1, 11:   rom[k] = ins(OpAlu, rd, rs, imm);
                2, 3:    rom[k] = ins(OpLdi, rd, rs, imm);
                4:       rom[k] = ins(OpJmp, rd, rs, tgt);
                5:       rom[k] = ins(OpJz, rd, rs, tgt);
                6:       rom[k] = ins(OpJnz, rd, rs, tgt);
                7:       rom[k] = ins(OpIn, rd, rs, imm);
                8:       rom[k] = ins(OpOut, rd, rs, imm);
                9:       rom[k] = ins(4'($urandom_range(9, 15)), rd, rs, imm);
                default: rom[k] = ins(OpLdi, rd, rs, imm);
            endcase
        end
        for (int r = 0; r < 4; r++) rom[n + r] = ins(OpOut, 0, r, 0);
        rom[n + 4] = ins(OpHalt, 0, 0, 0);
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int cyc = 0;
        while (bus.halted !== 1'b1 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, "_halted"}, bus.halted, 1);
        @(negedge clk);
        @(negedge clk);
        chk({name, "_out_drain"}, out_exp.size(), 0);
        chk({name, "_pc_drain"}, pc_exp.size(), 0);
    endtask

    task automatic do_reset(input string name);
        mon_en = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({name, "_out_valid"}, bus.out_valid, 0);
        chk({name, "_busy"}, bus.busy, 0);
        chk({name, "_halted"}, bus.halted, 0);
        chk({name, "_in_ready"}, bus.in_ready, 0);
        chk({name, "_zflag"}, bus.zflag, 0);
        chk({name, "_pc"}, bus.imem_addr, 0);
        chk({name, "_out_data"}, bus.out_data, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, "_idle_busy"}, bus.busy, 0);
        chk({name, "_idle_pc"}, bus.imem_addr, 0);
        pc_exp.delete();
        out_exp.delete();
        in_model.delete();
        in_feed.delete();
        m_pc = 8'd0;
        m_z  = 1'b0;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        mon_en = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        clear_rom();
        do_reset("reset");

        // ALU op with operands from R0/R1
        clear_rom();
        rom[0] = ins(OpLdi, 0, 0, 8'h05);
        rom[1] = ins(OpLdi, 1, 0, 8'h09);
        rom[2] = ins(OpAlu, 1, 0, 1);
        rom[3] = ins(OpOut, 0, 1, 0);
        rom[4] = ins(OpHalt, 0, 0, 0);
        model_run();
        pulse_start();
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("alu_a", bus.alu_a, 8'h05);
        chk("alu_b", bus.alu_b, 8'h09);
        chk("alu_s", bus.alu_s, 1);
        chk("alu_exec_pc", bus.imem_addr, 2);
        @(posedge clk);
        @(negedge clk);
        chk("alu_zflag", bus.zflag, 1);
        chk("alu_next_pc", bus.imem_addr, 3);
        wait_halt("alu");

        // Compare flag feeding JZ (not taken) then JNZ (taken)
        for (int v = 0; v < 2; v++) begin
            clear_rom();
            rom[0]    = ins(OpLdi, 2, 0, 8'h0F);
            rom[1]    = ins(OpLdi, 3, 0, 8'h0F);
            rom[2]    = ins(OpAlu, 3, 2, 0);
            rom[3]    = ins((v == 0) ? OpJz : OpJnz, 0, 0, 8'h20);
            rom[4]    = ins(OpOut, 0, 3, 0);
            rom[5]    = ins(OpHalt, 0, 0, 0);
            rom[8'h20] = ins(OpOut, 0, 2, 0);
            rom[8'h21] = ins(OpHalt, 0, 0, 0);
            model_run();
            pulse_start();
            repeat (12) @(posedge clk);
            @(negedge clk);
            chk("cmp_zflag", bus.zflag, 0);
            chk((v == 0) ? "jz_pc" : "jnz_pc", bus.imem_addr, (v == 0) ? 4 : 8'h20);
            wait_halt((v == 0) ? "jz" : "jnz");
        end

        // IN with delayed valid, OUT with backpressure
        clear_rom();
        rom[0] = ins(OpIn, 1, 0, 0);
        rom[1] = ins(OpOut, 0, 1, 0);
        rom[2] = ins(OpHalt, 0, 0, 0);
        in_model.delete(); in_feed.delete();
        in_model.push_back(8'hA5); in_feed.push_back(8'hA5);
        in_cfg  = 5;
        out_cfg = 3;
        model_run();
        pulse_start();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("exec_in_ready", bus.in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("wait_in_ready", bus.in_ready, 1);
        wait_halt("inout");
        in_cfg  = -1;
        out_cfg = -1;

        // Random programs against the model
        for (int p = 0; p < 10; p++) begin
            gen_random(16);
            set_inputs(20);
            model_run();
            pulse_start();
            wait_halt("random");
        end

        // HALT keeps registers; restart from 0; start during FETCH is ignored
        chk("halt_halted", bus.halted, 1);
        chk("halt_busy", bus.busy, 0);
        clear_rom();
        rom[0] = ins(OpNop, 0, 0, 0);
        for (int r = 0; r < 4; r++) rom[1 + r] = ins(OpOut, 0, r, 0);
        rom[5] = ins(OpHalt, 0, 0, 0);
        out_cfg = 0;
        model_run();
        pulse_start();
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("fetch_start_busy", bus.busy, 1);
        chk("fetch_start_pc", bus.imem_addr, 1);
        wait_halt("restart");
        out_cfg = -1;

        // Reset while waiting in WAIT_OUT
        clear_rom();
        rom[0] = ins(OpLdi, 0, 0, 8'h3C);
        rom[1] = ins(OpOut, 0, 0, 0);
        rom[2] = ins(OpHalt, 0, 0, 0);
        out_cfg = 100;
        model_run();
        pulse_start();
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("midout_valid", bus.out_valid, 1);
        chk("midout_data", bus.out_data, 8'h3C);
        do_reset("midout_reset");
        out_cfg = -1;

        // Registers cleared by reset
        clear_rom();
        for (int r = 0; r < 4; r++) rom[r] = ins(OpOut, 0, r, 0);
        rom[4] = ins(OpHalt, 0, 0, 0);
        model_run();
        pulse_start();
        wait_halt("cleared");

        // PC wraps from 255 to 0
        clear_rom();
        rom[0]    = ins(OpJz, 0, 0, 8'h10);
        rom[1]    = ins(OpLdi, 0, 0, 8'h00);
        rom[2]    = ins(OpLdi, 1, 0, 8'h01);
        rom[3]    = ins(OpAlu, 1, 0, 1);
        rom[4]    = ins(OpJmp, 0, 0, 8'hFF);
        rom[8'hFF] = ins(OpNop, 0, 0, 0);
        rom[8'h10] = ins(OpOut, 0, 1, 0);
        rom[8'h11] = ins(OpHalt, 0, 0, 0);
        model_run();
        pulse_start();
        wait_halt("wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
